parity_accumulator: RTL and testbench
=====================================

PARITY_ACCUMULATOR -- requirements
Module: parity_accumulator

Interface
REQ-001 Parameter FRAME_LEN, default 8, data bits per frame; legal range 1..255.
REQ-002 Parameter ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous frame abort, active-high.
REQ-006 in_valid  input  1  in_bit is valid this cycle.
REQ-007 in_bit  input  1  serial data bit, stream from the upstream XOR stage.
REQ-008 in_ready  output  1  block accepts in_bit this cycle.
REQ-009 out_valid  output  1  out_parity (and out_error) are valid.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_parity  output  1  computed parity of the completed frame.
REQ-012 out_error  output  1  parity mismatch flag; see Configuration.

Function
REQ-013 Transfer on input side SHALL occur only when in_valid && in_ready; on output side only when out_valid && out_ready.
REQ-014 FSM SHALL have states IDLE, ACCUM, DONE (plus CHECK under PARITY_CHECK_EN).
REQ-015 IDLE: in_ready=1, out_valid=0; on input transfer, par <= ODD ^ in_bit, cnt <= 1; next state ACCUM, or DONE if FRAME_LEN==1.
REQ-016 ACCUM: in_ready=1; each input transfer does par <= par ^ in_bit, cnt <= cnt+1; cycles without in_valid hold par and cnt.
REQ-017 ACCUM SHALL move to DONE on the transfer that makes cnt equal FRAME_LEN; cnt never exceeds FRAME_LEN, no wrap.
REQ-018 DONE: in_ready=0, out_valid=1, out_parity=par held stable until output transfer; then IDLE with cnt=0, par=ODD.
REQ-019 Latency: out_valid SHALL assert the cycle after the last data bit's transfer.
REQ-020 Backpressure: out_ready low in DONE SHALL stall indefinitely with no input accepted and outputs stable.
REQ-021 cnt width SHALL be $clog2(FRAME_LEN+1) bits.
REQ-022 clr SHALL take priority over all transfers: next state IDLE, cnt=0, par=ODD, out_valid deasserts next cycle; a bit presented with clr is discarded.
REQ-023 No new frame bit SHALL be accepted in the same cycle as the output transfer; the next frame starts earliest the cycle after.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, cnt=0, par=ODD, out_valid=0, out_parity=0, out_error=0, in_ready=0 while rst_n low.
REQ-025 Reset mid-frame SHALL discard the partial frame; after rst_n rises, in_ready=1 on the first clock.

Configuration
REQ-026 Macro PARITY_CHECK_EN: when defined, each frame is FRAME_LEN data bits followed by one received parity bit.
REQ-027 With PARITY_CHECK_EN, ACCUM goes to CHECK after the last data bit; CHECK has in_ready=1 and on transfer sets out_error = par ^ in_bit, then enters DONE; out_parity still reports computed par.
REQ-028 Without PARITY_CHECK_EN, no CHECK state exists, out_error SHALL be constant 0, and frame length is exactly FRAME_LEN bits.

Verification
REQ-029 FRAME_LEN=8, ODD=0, bits 1,0,1,1,0,0,0,0 with in_valid continuous -> out_valid on cycle 9, out_parity=1, in_ready=0 while out_valid.
REQ-030 Same bits, ODD=1 -> out_parity=0; all-zero frame with ODD=0 -> out_parity=0.
REQ-031 in_valid gaps of 3 cycles between bits, out_ready held low 5 cycles in DONE -> parity unchanged, out_valid and out_parity stable throughout, no extra bits accepted.
REQ-032 clr asserted after 4 of 8 bits, then full frame 1,1,1,1,1,1,1,0 -> out_parity=1, first 4 bits have no effect.
REQ-033 rst_n pulsed low mid-frame (asynchronously, between edges) -> out_valid=0 and in_ready=0 immediately, fresh frame after release yields correct parity.
REQ-034 PARITY_CHECK_EN, ODD=0, data 1,0,0,0,0,0,0,0 with parity bit 1 -> out_error=0; parity bit 0 -> out_error=1, out_parity=1 in both.

Source files
------------

// File: rtl/parity_accumulator_if.sv
// parity_accumulator_if
//   Handshake bundle between the parity accumulator and its neighbours.
//   master : upstream/downstream side (drives clr, in_valid, in_bit, out_ready)
//   slave  : the accumulator itself
//   Signals:
//     clr        synchronous frame abort, active-high
//     in_valid   in_bit is valid this cycle
//     in_bit     serial data bit
//     in_ready   accumulator accepts in_bit this cycle
//     out_valid  out_parity / out_error are valid
//     out_ready  downstream consumes the result
//     out_parity computed parity of the completed frame
//     out_error  received-parity mismatch flag
interface parity_accumulator_if;
    logic clr;
    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_parity;
    logic out_error;

    modport master (
        output clr, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_parity, out_error
    );

    modport slave (
        input  clr, in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_parity, out_error
    );
endinterface

// File: rtl/parity_accumulator.sv
// parity_accumulator
//   Accumulates the parity of a serial frame of FRAME_LEN bits and hands the
//   result downstream with a valid/ready handshake. Optionally (macro
//   PARITY_CHECK_EN) each frame carries one trailing received parity bit
//   that is compared against the computed parity to raise out_error.
//   Parameters:
//     FRAME_LEN  data bits per frame, 1..255
//     ODD        0 = even parity, 1 = odd parity
//   Ports:
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        parity_accumulator_if.slave handshake bundle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for first bit of a frame
// ACCUM | collecting remaining data bits
// CHECK | waiting for received parity bit (PARITY_CHECK_EN only)
// DONE  | result presented, waiting for out_ready
module parity_accumulator #(
    parameter int unsigned FRAME_LEN = 8,
    parameter bit          ODD       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_accumulator_if.slave  bus
);
    localparam int            CW  = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(FRAME_LEN);
    localparam logic [CW-1:0] ONE = CW'(1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2, CHECK = 2'd3} state_t;
    localparam state_t AFTER_DATA = CHECK;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          par_q, par_d;
`ifdef PARITY_CHECK_EN
    logic          err_q, err_d;
`endif

    logic in_ready;
    logic in_fire;
    logic out_fire;

    // in_ready is gated by rst_n so it drops the instant reset asserts,
    // not at the next clock edge.
    assign in_ready = rst_n && (state_q != DONE);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = (state_q == DONE) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= ODD;
`ifdef PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
`ifdef PARITY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
`ifdef PARITY_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    par_d   = ODD ^ bus.in_bit;
                    cnt_d   = ONE;
`ifdef PARITY_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = (LEN == ONE) ? AFTER_DATA : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    par_d = par_q ^ bus.in_bit;
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == LEN) begin
                        state_d = AFTER_DATA;
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            CHECK: begin
                if (in_fire) begin
                    err_d   = par_q ^ bus.in_bit;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_fire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    par_d   = ODD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                par_d   = ODD;
            end
        endcase

        // Abort wins over any transfer in the same cycle.
        if (bus.clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            par_d   = ODD;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_parity = (state_q == DONE) && par_q;
`ifdef PARITY_CHECK_EN
    assign bus.out_error  = (state_q == DONE) && err_q;
`else
    assign bus.out_error  = 1'b0;
`endif
endmodule

// File: tb/tb_parity_accumulator.sv
module tb_parity_accumulator;
    localparam int FLEN = 8;
`ifdef PARITY_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NEED = FLEN + CHK;

    logic clk;
    logic rst_n;
    logic clr, in_valid, in_bit, out_ready;

    parity_accumulator_if if0 ();
    parity_accumulator_if if1 ();

    assign if0.clr = clr;  assign if0.in_valid = in_valid;
    assign if0.in_bit = in_bit;  assign if0.out_ready = out_ready;
    assign if1.clr = clr;  assign if1.in_valid = in_valid;
    assign if1.in_bit = in_bit;  assign if1.out_ready = out_ready;

    parity_accumulator #(.FRAME_LEN(FLEN), .ODD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    parity_accumulator #(.FRAME_LEN(FLEN), .ODD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // bit 0 = even-parity instance, bit 1 = odd-parity instance
    wire [1:0] rdy = {if1.in_ready,   if0.in_ready};
    wire [1:0] vld = {if1.out_valid,  if0.out_valid};
    wire [1:0] par = {if1.out_parity, if0.out_parity};
    wire [1:0] err = {if1.out_error,  if0.out_error};

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bits of the frame in progress in a queue; once the
    // frame is complete the result is held until consumed.
    bit       q[$];
    bit       m_done;
    bit [1:0] m_par;
    bit [1:0] m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
        end else if (clr) begin
            q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (in_valid) begin
            q.push_back(in_bit);
            if (q.size() == NEED) begin
                bit x;
                x = 1'b0;
                for (int i = 0; i < FLEN; i++) x ^= q[i];
                m_par = {~x, x};
                m_err = 2'b00;
                if (CHK != 0) m_err = m_par ^ {2{q[FLEN]}};
                m_done = 1'b1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready",   rdy, {2{rst_n && !m_done}});
        check("cyc_out_valid",  vld, {2{m_done}});
        check("cyc_out_parity", par, m_done ? m_par : 2'b00);
        check("cyc_out_error",  err, m_done ? m_err : 2'b00);
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1; in_bit = b;
        @(negedge clk); #1;
        in_valid = 1'b0; in_bit = 1'b0;
    endtask

    // MSB first; gap idle cycles between bits, none after the last one.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            if (i > 0 || CHK != 0) idle(gap);
        end
        if (CHK != 0) send_bit(pbit);
    endtask

    task automatic check_result(input string nm, input logic [1:0] exp_par);
        check({nm, "_valid"},  vld, 2'b11);
        check({nm, "_ready"},  rdy, 2'b00);
        check({nm, "_parity"}, par, exp_par);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_ready",  rdy, 2'b00);
        check("rst_valid",  vld, 2'b00);
        check("rst_parity", par, 2'b00);
        check("rst_error",  err, 2'b00);
        #21 rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_ready", rdy, 2'b11);

        // continuous stream: result right after the 8th bit
        send_frame(8'b1011_0000, 1'b0, 0);
        check_result("f1", 2'b01);
        consume();

        send_frame(8'b0000_0000, 1'b0, 0);
        check_result("f2_zero", 2'b10);
        consume();

        // gapped input, then stall with in_valid held high
        send_frame(8'b1110_0101, 1'b0, 3);
        check_result("f3_gap", 2'b01);
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("f3_hold_valid",  vld, 2'b11);
            check("f3_hold_parity", par, 2'b01);
            check("f3_hold_ready",  rdy, 2'b00);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("f3_after_valid", vld, 2'b00);
        check("f3_after_ready", rdy, 2'b11);

        // abort after 4 bits; the bit offered with clr is dropped
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        send_frame(8'b1111_1110, 1'b0, 0);
        check_result("f4_clr", 2'b01);
        consume();

        // async reset mid-frame
        repeat (5) send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", rdy, 2'b00);
        check("mid_rst_valid", vld, 2'b00);
        @(negedge clk); #3 rst_n = 1'b1;
        @(negedge clk); #1;
        send_frame(8'b0000_0001, 1'b0, 0);
        check_result("f5_fresh", 2'b01);
        consume();

        // async reset while result is pending
        send_frame(8'b1100_0000, 1'b0, 0);
        check_result("f6", 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("done_rst_valid",  vld, 2'b00);
        check("done_rst_parity", par, 2'b00);
        check("done_rst_ready",  rdy, 2'b00);
        @(negedge clk); #3 rst_n = 1'b1;
        @(negedge clk); #1;

        // received parity bit 1, then 0
        send_frame(8'b1000_0000, 1'b1, 0);
        check_result("f7", 2'b01);
        check("f7_error", err, (CHK != 0) ? 2'b10 : 2'b00);
        consume();
        send_frame(8'b1000_0000, 1'b0, 0);
        check_result("f8", 2'b01);
        check("f8_error", err, (CHK != 0) ? 2'b01 : 2'b00);
        consume();

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
